// File: rtl/uart_rx_pkg.sv
// Shared types and width helpers for the UART receive front end.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic int half_of(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

    function automatic int cnt_width(input int clks_per_bit);
        return $clog2(clks_per_bit);
    endfunction

    function automatic int idx_width(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit timer: one strobe half a bit after clear, then one strobe per full bit.
// bit_idx counts full-bit strobes and saturates at DATA_BITS.
module rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    localparam int CNT_W       = cnt_width(CLKS_PER_BIT),
    localparam int IDX_W       = idx_width(DATA_BITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic             sample_strobe,
    output logic [IDX_W-1:0] bit_idx
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(half_of(CLKS_PER_BIT) - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             half_done_q, half_done_d;

    always_comb begin
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        half_done_d   = half_done_q;
        sample_strobe = 1'b0;
        if (clear) begin
            cnt_d       = '0;
            idx_d       = '0;
            half_done_d = 1'b0;
        end else if (enable) begin
            if (!half_done_q) begin
                if (cnt_q == HALF_M1) begin
                    sample_strobe = 1'b1;
                    half_done_d   = 1'b1;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (cnt_q == FULL_M1) begin
                sample_strobe = 1'b1;
                cnt_d         = '0;
                if (idx_q != IDX_MAX) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            half_done_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            half_done_q <= half_done_d;
        end
    end

    assign bit_idx = idx_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: line synchroniser, start/data/stop FSM, shift register and
// a ready/read output handshake with framing and overrun flags.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 busy
);

    localparam int IDX_W = idx_width(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    rx_state_t state_q, state_d;

    logic sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, rx_data_q, rx_data_d;
    logic data_ready_q, data_ready_d, fe_q, fe_d, oe_q, oe_d;

    logic             line, start_edge;
    logic             timer_clear, timer_enable, sample_strobe;
    logic [IDX_W-1:0] bit_idx;
    logic             shift_en, start_ok, frame_good, frame_bad;

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .DATA_BITS   (DATA_BITS)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .clear        (timer_clear),
        .enable       (timer_enable),
        .sample_strobe(sample_strobe),
        .bit_idx      (bit_idx)
    );

    assign line       = sync2_q;
    assign start_edge = !sync2_q && hist_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_edge) state_d = START_CHK;
            START_CHK: if (sample_strobe) state_d = line ? IDLE : DATA;
            DATA:      if (sample_strobe && bit_idx == LAST_IDX) state_d = STOP;
            STOP:      if (sample_strobe) state_d = line ? IDLE : BREAK;
            BREAK:     if (line) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Timer is held cleared while idle, so the first active cycle counts from 0.
    always_comb begin
        busy         = (state_q != IDLE);
        timer_clear  = (state_q == IDLE);
        timer_enable = (state_q == START_CHK) || (state_q == DATA) || (state_q == STOP);
        shift_en     = (state_q == DATA) && sample_strobe;
        start_ok     = (state_q == START_CHK) && sample_strobe && !line;
        frame_good   = (state_q == STOP) && sample_strobe && line;
        frame_bad    = (state_q == STOP) && sample_strobe && !line;
    end

    always_comb begin
        sync1_d      = serial_in;
        sync2_d      = sync1_q;
        hist_d       = sync2_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        data_ready_d = data_ready_q;
        fe_d         = fe_q;
        oe_d         = oe_q;
        if (shift_en) begin
            shift_d              = shift_q >> 1;
            shift_d[DATA_BITS-1] = line;
        end
        if (data_read) begin
            data_ready_d = 1'b0;
            oe_d         = 1'b0;
        end
        // A load in the same cycle as a read wins over the read.
        if (frame_good) begin
            rx_data_d    = shift_q;
            data_ready_d = 1'b1;
            if (data_ready_q && !data_read) oe_d = 1'b1;
        end
        if (start_ok)  fe_d = 1'b0;
        if (frame_bad) fe_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            hist_q       <= 1'b1;
            rx_data_q    <= '0;
            data_ready_q <= 1'b0;
            fe_q         <= 1'b0;
            oe_q         <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            hist_q       <= hist_d;
            rx_data_q    <= rx_data_d;
            data_ready_q <= data_ready_d;
            fe_q         <= fe_d;
            oe_q         <= oe_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = data_ready_q;
    assign framing_error = fe_q;
    assign overrun_error = oe_q;

endmodule
